// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : decoder_rr_arbiter
// Brief    : 16-way round-robin arbiter with a hold limit and a one-hot grant
//            decoded from registered state. The optional grant lock is
//            enabled by defining DECODER_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
`ifdef DECODER_ARB_LOCK_EN
  input  logic        lock,
`endif
  output logic [3:0]  grant_idx,
  output logic        grant_valid,
  output logic [15:0] grant_onehot,
  output logic        hold_expired
);

  localparam logic [0:0]       c_st_idle  = 1'b0;
  localparam logic [0:0]       c_st_grant = 1'b1;
  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [0:0]       r_state;
  logic [3:0]       r_idx;
  logic [3:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exp;

  logic [0:0]       w_nxt_state;
  logic [3:0]       w_nxt_idx;
  logic [3:0]       w_nxt_last;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_nxt_exp;

  logic             w_lock;
  logic             w_any;
  logic [3:0]       w_start;
  logic [31:0]      w_dbl;
  logic [15:0]      w_rot;
  logic [3:0]       w_off;
  logic [3:0]       w_pick;
  logic             w_hold_req;
  logic             w_valid;

`ifdef DECODER_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // Rotate the request vector so that the search start lands at bit 0;
  // the lowest set bit of the rotated vector is then the round-robin winner.
  assign w_any   = |req;
  assign w_start = r_last + 4'd1;
  assign w_dbl   = {req, req};
  assign w_rot   = 16'(w_dbl >> w_start);

  always_comb begin
    w_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = 4'(i);
      end
    end
  end

  assign w_pick     = w_start + w_off;
  assign w_hold_req = req[r_idx];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_last  = r_last;
    w_nxt_cnt   = r_cnt;
    w_nxt_exp   = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_any) begin
          w_nxt_state = c_st_grant;
          w_nxt_idx   = w_pick;
          w_nxt_last  = w_pick;
          w_nxt_cnt   = c_cnt_one;
        end
      end
      default: begin
        if (!w_hold_req) begin
          // Release: hand over in the same edge, or fall back to idle.
          if (w_any) begin
            w_nxt_idx  = w_pick;
            w_nxt_last = w_pick;
            w_nxt_cnt  = c_cnt_one;
          end else begin
            w_nxt_state = c_st_idle;
            w_nxt_cnt   = '0;
          end
        end else if (r_cnt < c_max_hold) begin
          w_nxt_cnt = r_cnt + c_cnt_one;
        end else if (w_lock) begin
          w_nxt_cnt = c_max_hold;
        end else begin
          // Expiry: r_last equals the grantee, so the search starts at g+1
          // and only comes back to g when nobody else is asking.
          w_nxt_exp  = 1'b1;
          w_nxt_idx  = w_pick;
          w_nxt_last = w_pick;
          w_nxt_cnt  = c_cnt_one;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_idx   <= 4'd0;
      r_last  <= 4'hF;
      r_cnt   <= '0;
      r_exp   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_last  <= w_nxt_last;
      r_cnt   <= w_nxt_cnt;
      r_exp   <= w_nxt_exp;
    end
  end

  assign w_valid      = (r_state == c_st_grant);
  assign grant_valid  = w_valid;
  assign grant_idx    = r_idx;
  assign hold_expired = r_exp;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
      assign grant_onehot[gi] = w_valid && (r_idx == 4'(gi));
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_rr_arbiter
// Brief    : Bench for decoder_rr_arbiter; two instances (MAX_HOLD 8 and 4)
//            share stimulus and are compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        lock;

  logic [3:0]  g8_idx, g4_idx;
  logic        g8_valid, g4_valid;
  logic [15:0] g8_oh, g4_oh;
  logic        g8_exp, g4_exp;

  int checks = 0;
  int errors = 0;

  decoder_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req),
`ifdef DECODER_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant_idx(g8_idx), .grant_valid(g8_valid),
    .grant_onehot(g8_oh), .hold_expired(g8_exp)
  );

  decoder_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
`ifdef DECODER_ARB_LOCK_EN
    .lock(lock),
`endif
    .grant_idx(g4_idx), .grant_valid(g4_valid),
    .grant_onehot(g4_oh), .hold_expired(g4_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed state per instance: {valid, idx (masked when idle), onehot, expired}
  logic [21:0] v8, v4;
  assign v8 = {g8_valid, g8_valid ? g8_idx : 4'd0, g8_oh, g8_exp};
  assign v4 = {g4_valid, g4_valid ? g4_idx : 4'd0, g4_oh, g4_exp};

  // Behavioural model: index 0 mirrors MAX_HOLD=8, index 1 mirrors MAX_HOLD=4
  int maxh [2] = '{8, 4};
  int m_valid [2];
  int m_idx [2];
  int m_last [2];
  int m_cnt [2];
  int m_exp [2];

  function automatic int search(int last, logic [15:0] r);
    for (int k = 1; k <= 16; k++) begin
      if (r[(last + k) % 16]) return (last + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 0; m_idx[k] = 0; m_last[k] = 15; m_cnt[k] = 0; m_exp[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int s;
        int take;
        s = search(m_last[k], req);
        take = 0;
        m_exp[k] = 0;
        if (m_valid[k] == 0) begin
          take = (s >= 0);
        end else if (!req[m_idx[k]]) begin
          if (s >= 0) take = 1;
          else m_valid[k] = 0;
        end else if (m_cnt[k] < maxh[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
        end else begin
          m_exp[k] = 1;
          take = 1;
        end
        if (take != 0) begin
          m_valid[k] = 1; m_idx[k] = s; m_last[k] = s; m_cnt[k] = 1;
        end
      end
    end
  end

  function automatic logic [21:0] mvec(int k);
    logic [15:0] oh;
    oh = (m_valid[k] != 0) ? (16'd1 << m_idx[k]) : 16'd0;
    return {1'(m_valid[k]), (m_valid[k] != 0) ? 4'(m_idx[k]) : 4'd0, oh, 1'(m_exp[k])};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 16'hFFFF;
    repeat (3) begin
      step();
      checks++;
      if ({g8_valid, g8_idx, g8_oh, g8_exp} !== 22'd0) begin
        errors++;
        $display("FAIL reset_dut8: got v=%b i=%0d oh=%h e=%b, need all zero", g8_valid, g8_idx, g8_oh, g8_exp);
      end
      checks++;
      if ({g4_valid, g4_idx, g4_oh, g4_exp} !== 22'd0) begin
        errors++;
        $display("FAIL reset_dut4: got v=%b i=%0d oh=%h e=%b, need all zero", g4_valid, g4_idx, g4_oh, g4_exp);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (v8 !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL first_grant_dut8: got %h, need %h", v8, {1'b1, 4'd0, 16'h0001, 1'b0});
    end
    checks++;
    if (v4 !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL first_grant_dut4: got %h, need %h", v4, {1'b1, 4'd0, 16'h0001, 1'b0});
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    req = 16'h0010;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (v8 !== {1'b1, 4'd4, 16'h0010, 1'b0} || v4 !== {1'b1, 4'd4, 16'h0010, 1'b0}) begin
        errors++;
        $display("FAIL single_hold cyc%0d: got %h / %h, need %h", n, v8, v4, {1'b1, 4'd4, 16'h0010, 1'b0});
      end
    end
    req = 16'h0;
    step();
    checks++;
    if (v8 !== 22'd0 || v4 !== 22'd0) begin
      errors++;
      $display("FAIL single_release: got %h / %h, need 0", v8, v4);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h8001;
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (g8_valid !== 1'b1 || g8_idx !== (((n / 8) % 2 == 0) ? 4'd0 : 4'd15) ||
          g8_exp !== ((n > 0) && (n % 8 == 0))) begin
        errors++;
        $display("FAIL wrap_dut8 cyc%0d: got v=%b i=%0d e=%b", n, g8_valid, g8_idx, g8_exp);
      end
      checks++;
      if (g4_valid !== 1'b1 || g4_idx !== (((n / 4) % 2 == 0) ? 4'd0 : 4'd15) ||
          g4_exp !== ((n > 0) && (n % 4 == 0))) begin
        errors++;
        $display("FAIL wrap_dut4 cyc%0d: got v=%b i=%0d e=%b", n, g4_valid, g4_idx, g4_exp);
      end
    end
  endtask

  task automatic test_sole_requester();
    do_reset();
    req = 16'h0020;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (v8 !== {1'b1, 4'd5, 16'h0020, 1'((n > 0) && (n % 8 == 0))}) begin
        errors++;
        $display("FAIL sole_dut8 cyc%0d: got %h", n, v8);
      end
      checks++;
      if (v4 !== {1'b1, 4'd5, 16'h0020, 1'((n > 0) && (n % 4 == 0))}) begin
        errors++;
        $display("FAIL sole_dut4 cyc%0d: got %h", n, v4);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 16'h0004;
    step();
    req = 16'h000E;
    step();
    step();
    checks++;
    if (g8_idx !== 4'd2 || g4_idx !== 4'd2 || !g8_valid || !g4_valid) begin
      errors++;
      $display("FAIL b2b_hold2: got %0d / %0d, need 2", g8_idx, g4_idx);
    end
    req = 16'h000A;
    step();
    checks++;
    if (v8 !== {1'b1, 4'd3, 16'h0008, 1'b0} || v4 !== {1'b1, 4'd3, 16'h0008, 1'b0}) begin
      errors++;
      $display("FAIL b2b_to3: got %h / %h, need idx 3", v8, v4);
    end
    req = 16'h0002;
    step();
    checks++;
    if (v8 !== {1'b1, 4'd1, 16'h0002, 1'b0} || v4 !== {1'b1, 4'd1, 16'h0002, 1'b0}) begin
      errors++;
      $display("FAIL b2b_to1: got %h / %h, need idx 1", v8, v4);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 16'h0080;
    repeat (3) step();
    checks++;
    if (g8_idx !== 4'd7 || !g8_valid) begin
      errors++;
      $display("FAIL midrst_pre: got %0d v=%b, need 7", g8_idx, g8_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (v8 !== 22'd0 || v4 !== 22'd0 || g8_idx !== 4'd0 || g4_idx !== 4'd0) begin
      errors++;
      $display("FAIL midrst_async: got %h / %h, need 0", v8, v4);
    end
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (v8 !== {1'b1, 4'd7, 16'h0080, 1'b0} || v4 !== {1'b1, 4'd7, 16'h0080, 1'b0}) begin
      errors++;
      $display("FAIL midrst_regrant: got %h / %h, need idx 7", v8, v4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: req = 16'($urandom);
        1: req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: req = req ^ (16'd1 << $urandom_range(0, 15));
        default: ;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
      checks++;
      if (v8 !== mvec(0)) begin
        errors++;
        $display("FAIL random_dut8 cyc%0d req=%h: got %h, need %h", n, req, v8, mvec(0));
      end
      checks++;
      if (v4 !== mvec(1)) begin
        errors++;
        $display("FAIL random_dut4 cyc%0d req=%h: got %h, need %h", n, req, v4, mvec(1));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0;
    lock  = 1'b0;
    #1;
    test_reset();
    test_single_hold();
    test_wrap();
    test_sole_requester();
    test_back_to_back();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-16 one-hot decoder output stage among 16 requesters.
- Produces a registered binary grant index plus a grant-valid qualifier; the one-hot grant vector is the decode of that pair (all-zero when not valid).
- Sits in front of any resource addressed by a one-hot select, e.g. a shared bus or row strobe.
- Bounds each grant's tenure with a hold counter so that no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a grant is held while its request stays high; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request vector; bit i high = requester i wants the resource.
- grant_idx  output  4  binary index of the current grantee.
- grant_valid  output  1  grant_idx is meaningful.
- grant_onehot  output  16  equals (1 << grant_idx) when grant_valid=1, else 16'b0.
- hold_expired  output  1  single-cycle pulse in the cycle a grant is revoked by the hold limit.

Behaviour:
- Reset, asserted asynchronously:
  - grant_idx=0, grant_valid=0, grant_onehot=0, hold_expired=0.
  - State=IDLE, hold count=0.
  - Round-robin pointer last=15, so the first search starts at requester 0.
- States:
  - IDLE: no grant held.
  - GRANT: grant_valid=1.
- Search function: lowest-numbered set bit of req, scanning circularly from (last+1) mod 16 through last. Wrap-around is 15→0.
- IDLE transitions:
  - If any req bit is set at edge N, then after edge N: state=GRANT, grant_idx=search result, last=search result, hold count=1, grant_valid=1.
  - This is 1-cycle latency from request to grant.
- GRANT, per edge, with g = grant_idx:
  - req[g]=1 and hold count < MAX_HOLD: keep the grant and increment hold count.
  - req[g]=0 (release): re-arbitrate in the same edge.
    - Any other req set: grant the search result, hold count=1. No idle gap.
    - None set: go to IDLE, grant_valid=0.
  - req[g]=1 and hold count == MAX_HOLD (expiry): hold_expired=1 for exactly the next cycle, then re-arbitrate with the search starting at g+1.
    - If g is the only requester, g is re-granted and hold count restarts at 1.
- Outputs are all registered; grant_onehot is decoded from the registered values, so it carries no combinational path from req.
- Changes to req bits other than g during GRANT have no effect until a release or expiry.
- The grant index never changes without passing through a release or expiry edge.
- Reset asserted mid-grant: outputs clear immediately (asynchronously). The first grant after reset is searched from requester 0.
- MAX_HOLD=1: every grant lasts exactly one cycle, and hold_expired pulses every cycle while the grantee keeps requesting.

Optional Feature:
- Macro: DECODER_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, the hold counter saturates at MAX_HOLD and expiry is suppressed. The grant is held as long as req[g]=1.
  - Release by req[g]=0 still works normally.
  - If lock falls while the count is at MAX_HOLD, expiry occurs on the next edge.
- When undefined: no lock port; the hold limit always applies.

Test Plan:
- Reset with req=16'hFFFF held → grant_valid=0 during reset. First edge after release gives grant_idx=0, grant_onehot=16'h0001.
- req=16'h0010 single pulse-and-hold, then dropped after 3 grant cycles → grant_idx=4 for 3 cycles, then IDLE with grant_onehot=0.
- MAX_HOLD=8, req=16'h8001 held constantly → grants alternate 0 (8 cycles), 15 (8 cycles), 0, … with a hold_expired pulse at each handover. Checks 15→0 wrap.
- Only req[5] held, MAX_HOLD=4 → grant_idx stays 5 and hold_expired pulses every 4th cycle.
- During the grant to 2, raise req[1] and req[3], then drop req[2] → next grant_idx=3 in the very next cycle with no gap; 1 is granted after 3 releases.
- rst_n pulsed low mid-grant to 7 → outputs zero before the next clock edge. With req=16'h0080 held, grant_idx=7 is regranted one edge after rst_n rises.
